bus_grant_responder: RTL

Responder end of the req/gnt/bus handshake. It detects a rising `req`, waits a programmed latency, and pulses `gnt` for one cycle. It captures the request word on the grant edge into a small FIFO and presents it downstream on a valid/ready port. It also flags requester protocol violations: bus not stable while requesting, request dropped before grant, grant outside the window, and request held past grant.

---
 rtl/bus_grant_responder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/bus_grant_responder.sv
// bus_grant_responder: responder side of the req/gnt/bus handshake.
// Detects a rising req, waits GNT_DELAY edges, pulses gnt for one cycle,
// captures the bus word on the grant edge into a FIFO and presents it on a
// valid/ready port. Requester protocol violations raise sticky error flags:
// [0] bus unstable, [1] request dropped, [2] grant timeout, [3] request held.
module bus_grant_responder #(
    parameter int DATA_W     = 32,
    parameter int GNT_DELAY  = 2,
    parameter int MAX_WAIT   = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [DATA_W-1:0] bus,
    output logic              gnt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              err_clr,
    output logic [3:0]        err_status
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(MAX_WAIT + 2);

    // Counter saturates one past MAX_WAIT so the timeout compare fires once.
    localparam logic [CNT_W-1:0] DELAY_M1 = CNT_W'(GNT_DELAY - 1);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] SAT_C    = CNT_W'(MAX_WAIT + 1);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        GNT,
        RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic              req_q;
    logic [DATA_W-1:0] ref_q, ref_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt_d;
    logic [3:0]        err_set;

    logic              push, pop, space;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A pop at this edge frees a slot for a grant decided at the same edge.
    assign space     = (count < DEPTH_C) || pop;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Next-state, grant and error-detection decode for the handshake FSM.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d = state_q;
        ref_d   = ref_q;
        cnt_d   = cnt_q;
        gnt_d   = 1'b0;
        err_set = '0;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && !req_q) begin
                    ref_d = bus;
                    cnt_d = CNT_W'(1);
                    if (GNT_DELAY == 1 && space) begin
                        gnt_d   = 1'b1;
                        state_d = GNT;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus != ref_q) err_set[0] = 1'b1;
                if (cnt_q == MAX_C) err_set[2] = 1'b1;
                if (cnt_q != SAT_C) cnt_d = cnt_q + 1'b1;
                if (!req) begin
                    err_set[1] = 1'b1;
                    state_d    = IDLE;
                end else if (cnt_q >= DELAY_M1 && space) begin
                    gnt_d   = 1'b1;
                    state_d = GNT;
                end
            end
            GNT: begin
                push = 1'b1;
                if (bus != ref_q) err_set[0] = 1'b1;
                state_d = RELEASE;
            end
            RELEASE: begin
                if (req) err_set[3] = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, request history, reference word and grant register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            ref_q   <= '0;
            cnt_q   <= '0;
            gnt     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together.
            state_q <= state_d;
            req_q   <= req;
            ref_q   <= ref_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
        end
    end

    // Sticky error flags; a flag being set wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_status <= '0;
        end else begin
            err_status <= (err_status & ~{4{err_clr}}) | err_set;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage write.
    // NOTE: storage is not reset; out_data is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus;
    end

endmodule
